// File: rtl/sort_pkg.sv
// Shared definitions for the bitonic sort front end: element/frame geometry,
// loader FSM states and the default sorter latency.
package sort_pkg;

  localparam int unsigned ELEM_W           = 3;
  localparam int unsigned N_ELEM           = 8;
  localparam int unsigned FRAME_W          = ELEM_W * N_ELEM;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned SORT_LATENCY_DEF = 7;

  typedef logic [ELEM_W-1:0]  elem_t;
  typedef logic [FRAME_W-1:0] frame_t;

  typedef enum logic [0:0] {
    FILL,
    HOLD
  } state_t;

  // Overwrite every slot above last_idx with the pad value.
  function automatic frame_t pad_frame(input frame_t frame, input logic [2:0] last_idx,
                                       input elem_t pad);
    frame_t f;
    f = frame;
    for (int k = 0; k < N_ELEM; k++) begin
      if (k > int'(last_idx)) begin
        f[k*ELEM_W +: ELEM_W] = pad;
      end
    end
    return f;
  endfunction

endpackage

// File: rtl/sort_tag_delay.sv
// Fixed-length shift register that walks a per-frame tag alongside the sorter
// pipeline, so the tag reaches the output on the same cycle as the sorted frame.
module sort_tag_delay #(
  parameter int unsigned LATENCY = 7,
  parameter int unsigned TAG_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out
);

  logic [TAG_W-1:0] stage_q [LATENCY];
  logic [TAG_W-1:0] stage_d [LATENCY];

  // Each stage takes the previous stage's value; stage 0 takes the new tag.
  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset drops every tag in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign tag_out = stage_q[LATENCY-1];

endmodule

// File: rtl/sort_frame_loader.sv
// Serial-to-frame loader for the 8x3-bit bitonic sorter. Collects elements over
// a valid/ready handshake, launches whole frames onto nums under credit control
// and flags when the matching sorted frame appears on the sorter output.
// Build option: define SORT_LOADER_PAD_EN to let s_last close a short frame,
// with the unused slots filled by PAD_VALUE.
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int unsigned       SORT_LATENCY = SORT_LATENCY_DEF,
  parameter int unsigned       CREDITS      = 2,
  parameter logic [ELEM_W-1:0] PAD_VALUE    = 3'b111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [ELEM_W-1:0]  s_data,
  input  logic               s_last,
  output logic [FRAME_W-1:0] nums,
  output logic               launch,
  output logic               sout_valid,
  output logic [CNT_W-1:0]   sout_count,
  input  logic               frame_taken,
  output logic [2:0]         credit
);

  localparam logic [2:0]  CREDIT_MAX = 3'(CREDITS);
  localparam int unsigned TAG_W      = 1 + CNT_W;

  state_t             state_q, state_d;
  logic   [2:0]       idx_q, idx_d;
  frame_t             frame_q, frame_d;
  logic   [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  frame_t             nums_q, nums_d;
  logic   [CNT_W-1:0] nums_cnt_q, nums_cnt_d;
  logic               launch_q, launch_d;
  logic   [2:0]       credit_q, credit_d;

  logic               accept;
  logic               last_in;
  logic               complete;
  frame_t             cur_frame;
  frame_t             done_frame;
  logic   [CNT_W-1:0] done_cnt;
  logic   [TAG_W-1:0] tag_in;
  logic   [TAG_W-1:0] tag_out;

  // Ready depends on state only, never on s_valid.
  assign s_ready = (state_q == FILL);
  assign accept  = s_valid && s_ready;

`ifdef SORT_LOADER_PAD_EN
  assign last_in    = s_last;
  assign done_frame = pad_frame(cur_frame, idx_q, PAD_VALUE);
`else
  logic unused_pad;
  assign unused_pad = s_last ^ (^PAD_VALUE);
  assign last_in    = 1'b0;
  assign done_frame = cur_frame;
`endif

  assign complete = accept && ((idx_q == 3'(N_ELEM - 1)) || last_in);
  assign done_cnt = {1'b0, idx_q} + 4'd1;

  // Assembly view including the element being accepted this cycle.
  always_comb begin
    cur_frame = frame_q;
    cur_frame[idx_q*ELEM_W +: ELEM_W] = s_data;
  end

  // Fill/hold sequencing and launch decision.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    nums_d      = nums_q;
    nums_cnt_d  = nums_cnt_q;
    launch_d    = 1'b0;

    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (complete) begin
            idx_d = '0;
            if (credit_q != 3'd0) begin
              launch_d   = 1'b1;
              nums_d     = done_frame;
              nums_cnt_d = done_cnt;
            end else begin
              // No room downstream: park the finished frame.
              state_d     = HOLD;
              frame_d     = done_frame;
              frame_cnt_d = done_cnt;
            end
          end else begin
            frame_d = cur_frame;
            idx_d   = idx_q + 3'd1;
          end
        end
      end
      HOLD: begin
        // A credit returned this same cycle is enough to release the frame.
        if ((credit_q != 3'd0) || frame_taken) begin
          launch_d   = 1'b1;
          nums_d     = frame_q;
          nums_cnt_d = frame_cnt_q;
          state_d    = FILL;
          idx_d      = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Credit accounting: a launch spends one, frame_taken returns one, both cancel.
  always_comb begin
    credit_d = credit_q;
    if (launch_d && !frame_taken) begin
      credit_d = credit_q - 3'd1;
    end else if (!launch_d && frame_taken && (credit_q != CREDIT_MAX)) begin
      credit_d = credit_q + 3'd1;
    end
  end

  // State, assembly and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      idx_q       <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      nums_q      <= '0;
      nums_cnt_q  <= '0;
      launch_q    <= 1'b0;
      credit_q    <= CREDIT_MAX;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      nums_q      <= nums_d;
      nums_cnt_q  <= nums_cnt_d;
      launch_q    <= launch_d;
      credit_q    <= credit_d;
    end
  end

  // Tag enters on the launch cycle and exits with the sorted frame.
  assign tag_in = {launch_q, launch_q ? nums_cnt_q : '0};

  sort_tag_delay #(
    .LATENCY (SORT_LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_delay (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign nums       = nums_q;
  assign launch     = launch_q;
  assign credit     = credit_q;
  assign sout_valid = tag_out[TAG_W-1];
  assign sout_count = tag_out[TAG_W-1] ? tag_out[CNT_W-1:0] : '0;

endmodule
